// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame geometry and default divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = 10;
  localparam int CLKS_PER_BIT_DEFAULT = 10416;

  // Clock cycles occupied by one complete 8N1 frame on the line.
  function automatic int frame_cycles(input int clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Bit-period counter: tick is high in the last cycle of every bit, clear holds the count at 0.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int             CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so frames can run back to back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 byte_done,
  output logic                 busy
);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 data_ready_q, data_ready_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 byte_done_q, byte_done_d;
  logic                 baud_clear;
  logic                 baud_tick;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  // Ready mirrors the next holding state, so it is low on any edge where the register empties.
  assign data_ready_d = ~hold_valid_d;

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    tx_d         = 1'b1;
    byte_done_d  = 1'b0;
    baud_clear   = 1'b0;

    if (data_valid && data_ready_q) begin
      hold_data_d  = data_in;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        baud_clear = 1'b1;
        if (hold_valid_q) begin
          shift_d      = hold_data_q;
          hold_valid_d = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          // Registered alongside tx, so the pulse lands on the final stop-bit cycle of the line.
          byte_done_d = 1'b1;
          if (hold_valid_q) begin
            shift_d      = hold_data_q;
            hold_valid_d = 1'b0;
            state_d      = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      data_ready_q <= 1'b1;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      tx_q         <= 1'b1;
      byte_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      data_ready_q <= data_ready_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      byte_done_q  <= byte_done_d;
    end
  end

  assign data_ready = data_ready_q;
  assign tx         = tx_q;
  assign byte_done  = byte_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line monitor captures every frame and is compared against frames built from the 8N1 rule.
module tb_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = uart_pkg::FRAME_BITS * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       byte_done;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx        (tx),
    .byte_done (byte_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: frame start is the first low sample while not inside a frame.
  int                   fall_q[$];
  logic [FRAME_CYC-1:0] frame_q[$];
  int                   done_q[$];
  logic [FRAME_CYC-1:0] cur;
  int                   pos;
  bit                   in_frame = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b0) in_frame = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (byte_done === 1'b1) done_q.push_back(cyc);
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1;
        pos      = 0;
        cur      = '0;
        fall_q.push_back(cyc);
      end
      if (in_frame) begin
        cur[pos] = tx;
        pos++;
        if (pos == FRAME_CYC) begin
          frame_q.push_back(cur);
          in_frame = 1'b0;
        end
      end
    end
  end

  // Reference: start 0, data LSB first, stop 1, each bit held CPB cycles.
  function automatic logic [FRAME_CYC-1:0] expand(input logic [7:0] b);
    logic [9:0]           fw;
    logic [FRAME_CYC-1:0] v;
    fw = {1'b1, b, 1'b0};
    for (int k = 0; k < FRAME_CYC; k++) v[k] = fw[k / CPB];
    return v;
  endfunction

  task automatic clear_mon();
    fall_q.delete();
    frame_q.delete();
    done_q.delete();
  endtask

  // Offers b until accepted; junk is driven on data_in while ready is low. Starts and ends on a negedge.
  task automatic drive_byte(input logic [7:0] b, input bit keep_valid, output int acc, output bit ok);
    ok         = 1'b0;
    acc        = -1;
    data_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (data_ready === 1'b1) begin
        data_in = b;
        acc     = cyc + 1;
        ok      = 1'b1;
        @(negedge clk);
        if (!keep_valid) data_valid = 1'b0;
        break;
      end
      data_in = 8'($urandom);
      @(negedge clk);
    end
    if (!ok) data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frame_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({tx, data_ready, busy, byte_done} !== 4'b1100) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: tx/ready/busy/done got %b expected 1100", i, {tx, data_ready, busy, byte_done});
      end
    end
    $display("reset: 100 idle cycles observed");
  endtask

  task automatic test_single();
    int acc;
    bit ok;
    clear_mon();
    drive_byte(8'hA5, 1'b0, acc, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_accept: accepted %0d expected 1", ok); end
    n_cmp++;
    if ({data_ready, busy} !== 2'b00) begin
      n_bad++; $display("FAIL single_after_accept: ready/busy got %b expected 00", {data_ready, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({data_ready, busy} !== 2'b11) begin
      n_bad++; $display("FAIL single_after_transfer: ready/busy got %b expected 11", {data_ready, busy});
    end
    wait_frames(1, 100);
    n_cmp++;
    if (frame_q.size() !== 1) begin
      n_bad++; $display("FAIL single_frame_count: got %0d expected 1", frame_q.size());
    end else begin
      $display("single: byte 0xa5 accepted @%0d, tx fell @%0d", acc, fall_q[0]);
      n_cmp++;
      if (fall_q[0] !== acc + 2) begin
        n_bad++; $display("FAIL single_latency: fall @%0d expected @%0d", fall_q[0], acc + 2);
      end
      n_cmp++;
      if (frame_q[0] !== expand(8'hA5)) begin
        n_bad++; $display("FAIL single_line: got %h expected %h", frame_q[0], expand(8'hA5));
      end
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_q.size() !== 1) begin
      n_bad++; $display("FAIL single_done_count: got %0d expected 1", done_q.size());
    end else if (fall_q.size() > 0) begin
      n_cmp++;
      if (done_q[0] !== fall_q[0] + FRAME_CYC - 1) begin
        n_bad++; $display("FAIL single_done_cycle: got @%0d expected @%0d", done_q[0], fall_q[0] + FRAME_CYC - 1);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: busy got %b expected 0", busy); end
  endtask

  task automatic check_frames(input string name, input logic [7:0] exp_b[$], input bit spaced);
    int n = exp_b.size();
    n_cmp++;
    if (frame_q.size() !== n) begin
      n_bad++; $display("FAIL %s_frame_count: got %0d expected %0d", name, frame_q.size(), n);
    end
    n_cmp++;
    if (done_q.size() !== n) begin
      n_bad++; $display("FAIL %s_done_count: got %0d expected %0d", name, done_q.size(), n);
    end
    for (int k = 0; k < n && k < frame_q.size(); k++) begin
      $display("%s: frame %0d byte 0x%02h fall @%0d", name, k, exp_b[k], fall_q[k]);
      n_cmp++;
      if (frame_q[k] !== expand(exp_b[k])) begin
        n_bad++; $display("FAIL %s_line[%0d]: got %h expected %h", name, k, frame_q[k], expand(exp_b[k]));
      end
      if (k < done_q.size()) begin
        n_cmp++;
        if (done_q[k] !== fall_q[k] + FRAME_CYC - 1) begin
          n_bad++; $display("FAIL %s_done_cycle[%0d]: got @%0d expected @%0d", name, k, done_q[k], fall_q[k] + FRAME_CYC - 1);
        end
      end
      if (spaced && k > 0) begin
        n_cmp++;
        if (fall_q[k] - fall_q[k-1] !== FRAME_CYC) begin
          n_bad++; $display("FAIL %s_spacing[%0d]: got %0d expected %0d", name, k, fall_q[k] - fall_q[k-1], FRAME_CYC);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[$];
    int acc;
    bit ok;
    bit all_ok = 1'b1;
    clear_mon();
    bytes = '{8'h01, 8'h02, 8'h03, 8'($urandom), 8'($urandom), 8'($urandom)};
    for (int k = 0; k < bytes.size(); k++) begin
      drive_byte(bytes[k], k != bytes.size() - 1, acc, ok);
      all_ok &= ok;
    end
    n_cmp++;
    if (!all_ok) begin n_bad++; $display("FAIL b2b_accept: all accepted %0d expected 1", all_ok); end
    wait_frames(bytes.size(), bytes.size() * FRAME_CYC + 100);
    wait_idle();
    repeat (50) @(negedge clk);
    check_frames("b2b", bytes, 1'b1);
  endtask

  task automatic test_zero();
    logic [7:0] bytes[$];
    int acc;
    bit ok;
    clear_mon();
    bytes = '{8'h00};
    drive_byte(8'h00, 1'b0, acc, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL zero_accept: accepted %0d expected 1", ok); end
    wait_frames(1, 100);
    repeat (5) @(negedge clk);
    check_frames("zero", bytes, 1'b0);
    n_cmp++;
    if ({busy, data_ready} !== 2'b01) begin
      n_bad++; $display("FAIL zero_no_stall: busy/ready got %b expected 01", {busy, data_ready});
    end
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    int acc;
    bit ok;
    bit all_ok = 1'b1;
    clear_mon();
    for (int k = 0; k < 8; k++) begin
      bytes.push_back(8'($urandom));
      repeat ($urandom_range(0, 50)) @(negedge clk);
      drive_byte(bytes[k], 1'b0, acc, ok);
      all_ok &= ok;
    end
    n_cmp++;
    if (!all_ok) begin n_bad++; $display("FAIL random_accept: all accepted %0d expected 1", all_ok); end
    wait_frames(bytes.size(), bytes.size() * FRAME_CYC + 200);
    wait_idle();
    check_frames("random", bytes, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes[$];
    int  acc;
    int  target;
    bit  ok;
    bit  quiet = 1'b1;
    clear_mon();
    drive_byte(8'h3C, 1'b0, acc, ok);
    drive_byte(8'hC3, 1'b0, acc, ok);
    for (int i = 0; i < 20 && fall_q.size() < 1; i++) @(negedge clk);
    n_cmp++;
    if (fall_q.size() !== 1) begin
      n_bad++; $display("FAIL rstmid_start: falls got %0d expected 1", fall_q.size());
    end else begin
      target = fall_q[0] + 4 * CPB + CPB / 2;
      for (int i = 0; i < 100 && cyc < target; i++) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({tx, data_ready, busy, byte_done} !== 4'b1100) begin
      n_bad++; $display("FAIL rstmid_after: tx/ready/busy/done got %b expected 1100", {tx, data_ready, busy, byte_done});
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || byte_done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL rstmid_quiet: line quiet got %0d expected 1", quiet); end
    n_cmp++;
    if ({frame_q.size(), done_q.size()} !== {32'd0, 32'd0}) begin
      n_bad++; $display("FAIL rstmid_discard: frames/dones got %0d/%0d expected 0/0", frame_q.size(), done_q.size());
    end
    $display("rstmid: reset applied mid-frame, line idle afterwards");
    clear_mon();
    bytes = '{8'h5A};
    drive_byte(8'h5A, 1'b0, acc, ok);
    wait_frames(1, 100);
    repeat (5) @(negedge clk);
    check_frames("rstmid", bytes, 1'b0);
    if (fall_q.size() > 0) begin
      n_cmp++;
      if (fall_q[0] !== acc + 2) begin
        n_bad++; $display("FAIL rstmid_latency: fall @%0d expected @%0d", fall_q[0], acc + 2);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains bytes from the game-side send sequencer onto the PC-facing UART line. Accepts one byte per valid/ready handshake into a single holding register, then frames it as 8N1: start bit, 8 data bits LSB first, stop bit. Pulses `byte_done` at the end of every stop bit so the sequencer can advance to its next data source.

## Interface
- `CLKS_PER_BIT`, default 10416 (100 MHz / 9600 baud): clock cycles per serial bit; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data_in`  in  8  byte to transmit, sampled on handshake.
- `data_valid`  in  1  upstream has a byte on `data_in`.
- `data_ready`  out  1  holding register empty; byte accepted on any edge where `data_valid && data_ready`.
- `tx`  out  1  serial line, idle high, registered.
- `byte_done`  out  1  one-cycle pulse in the last cycle of a stop bit.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Reset values: `tx`=1, `data_ready`=1, `byte_done`=0, `busy`=0, state=IDLE, holding register empty, counters 0.
- Holding register (`hold_data`, `hold_valid`): loaded on handshake; `data_ready` is a registered `!hold_valid`. No accept on the same edge the register empties.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `hold_valid`, move `hold_data` to the shift register, clear `hold_valid`, go to START with baud counter 0.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit; shift right each bit end; after bit index 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles; `byte_done` asserted in the final cycle. At the STOP end, if `hold_valid`, load next byte and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1, wraps to 0 at each bit boundary. Bit index is 3 bits and saturates at 7.
- All byte values, including 8'h00, are transmitted normally. No value is special-cased.
- Upstream may hold `data_valid` high continuously. Each byte is taken exactly once per handshake.
- Reset mid-frame: on the next edge, `tx` returns to 1 and the in-flight and held bytes are discarded. `byte_done` is not pulsed for the aborted frame.

## Timing
- Accept edge E0: `hold_valid`=1 after E0. From IDLE, the FSM enters START at E1 and `tx` falls at E2 (`tx` is registered from state).
- Frame length is exactly 10×`CLKS_PER_BIT` cycles from the `tx` falling edge to the end of the stop bit.
- `byte_done` goes high for 1 cycle, coincident with the last stop-bit cycle. Back-to-back frames are therefore spaced exactly 10×`CLKS_PER_BIT`.
- `data_ready` drops the cycle after accept and rises the cycle after the holding register transfers to the shift register. This leaves a full frame to refill, so sustained throughput is one byte per frame.
- `busy` rises with START and falls on the return to IDLE.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_tx_state_t`.
  - Frame constants: DATA_BITS=8, frame length 10.
  - Default `CLKS_PER_BIT`, so the RX side uses the same divisor.
- Sub-module `baud_tick_gen`:
  - Parameterised counter with `clear` input and `tick` output (high on count = `CLKS_PER_BIT`-1).
  - Reused by the future receiver.
- The top level holds the FSM, the holding register and the shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset release, no traffic -> `tx`=1, `data_ready`=1, `busy`=0, `byte_done`=0 for 100 cycles.
- Single byte 8'hA5 -> `tx` falls 2 cycles after accept. Line reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. One `byte_done` pulse in cycle 40 of the frame.
- `data_valid` held high with 8'h01, 8'h02, 8'h03 -> three frames with no idle gap, `byte_done` pulses 40 cycles apart, each byte sent exactly once.
- Byte 8'h00 -> a full frame with 9 low bits then a high stop bit; `byte_done` pulses; no stall.
- `rst_n` low for 1 cycle in the middle of DATA bit 3, with a held byte pending -> `tx`=1 next cycle, no `byte_done`, `data_ready`=1. The next accepted byte frames cleanly.
- `data_valid` asserted while `data_ready`=0 -> byte not taken; `data_in` may change freely until `data_ready` returns to 1.
